conv_sequencer: RTL
===================

Name: conv_sequencer

Overview:
- Multi-cycle controller that sequences the shared filter-GPU ALU to compute one output pixel of a TAPS-tap convolution, e.g. a 3x3 kernel.
- For each tap it reads one window pixel and one kernel coefficient, issues MUL and then ADD to the ALU, and accumulates the result.
- After the last tap it scales and clamps the sum to an 8-bit pixel.
- Sits between the pixel window/kernel buffers and the ALU; it is the only ALU master while busy.

Parameters:
- TAPS, 9, number of kernel taps per output pixel (2..16).
- DATA_W, 16, ALU operand/result width; accumulator width.
- SHIFT, 4, arithmetic right shift applied to the final sum (kernel normalisation).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request one output pixel; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done (inclusive).
- done  out  1  one-cycle pulse; pix_out valid in the same cycle.
- pix_out  out  8  result pixel, held until the next done.
- win_addr  out  4  tap index to the window and kernel buffers.
- win_pix  in  8  unsigned window pixel; valid one cycle after win_addr.
- win_coef  in  8  signed coefficient; valid one cycle after win_addr.
- alu_ctrl  out  3  ALUControl: ADD=000, SUB=011, MUL=100, CONV=101, NOP=111.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_result  in  DATA_W  combinational ALU result; sampled at the end of the issue cycle.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, busy=0, done=0, pix_out=0, win_addr=0, alu_ctrl=111, alu_a=0, alu_b=0, accumulator=0, product register=0, tap counter=0. A reset asserted mid-operation aborts it immediately; no done pulse is produced.
- States:
  - IDLE: alu_ctrl=111. start=1 clears acc and tap=0, then goes to FETCH.
  - FETCH: win_addr=tap, alu_ctrl=111, then goes to MUL.
  - MUL: alu_ctrl=100, alu_a=zero-extend(win_pix), alu_b=sign-extend(win_coef). Register prod<=alu_result, then go to ACC.
  - ACC: alu_ctrl=000, alu_a=acc, alu_b=prod. Register acc<=alu_result. If tap==TAPS-1, go to OUT; else tap<=tap+1 and go to FETCH.
  - OUT: alu_ctrl=111. Register pix_out<=scale(acc), then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Latency: start sampled at edge t0 gives done high in cycle t0+3*TAPS+2 (29 cycles for TAPS=9). A back-to-back start is accepted in the first IDLE cycle after DONE.
- start while busy: ignored, not queued.
- Arithmetic:
  - The accumulator wraps modulo 2^DATA_W, as produced by the ALU; the sequencer never widens it.
  - scale(x) = x >>> SHIFT (signed), then reduced to 8 bits (see Optional Feature).
- alu_a and alu_b are 0 in every state other than MUL and ACC.
- win_addr holds its last value outside FETCH.

Optional Feature:
- Macro CONV_SEQ_SAT_EN.
- Defined: scale clamps the shifted value to 0..255; negative results become 0, values above 255 become 255.
- Undefined: scale takes the low 8 bits of the shifted value (truncation, wrap-around).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> busy=0, done=0, pix_out=0, alu_ctrl=111, win_addr=0.
- Identity kernel, SHIFT=4: coef[4]=16, all others 0, pix[4]=200 -> done exactly 29 cycles after start, pix_out=200. Verify the MUL/ADD sequence on alu_ctrl: 111,100,000 repeated 9 times.
- Box blur: all coef=1, all pix=160, SHIFT=3 -> acc=1440, 1440>>>3=180, pix_out=180.
- Negative result: all coef=-1, all pix=50, SHIFT=0 -> acc=-450.
  - CONV_SEQ_SAT_EN defined: pix_out=0.
  - CONV_SEQ_SAT_EN undefined: pix_out=0x3E (low byte of -450).
- Overflow clamp: coef[0]=127, pix[0]=255, others 0, SHIFT=4 -> 32385>>>4=2024.
  - CONV_SEQ_SAT_EN defined: pix_out=255.
  - CONV_SEQ_SAT_EN undefined: pix_out=0xE8.
- Control corners:
  - start pulsed while busy has no effect; the original done still arrives at cycle 29.
  - rst_n=0 at cycle 10 -> IDLE next cycle, no done pulse, then a fresh start completes normally.

Source files
------------

// File: rtl/conv_sequencer.sv
// Multi-cycle convolution controller: drives the shared ALU through FETCH/MUL/ACC per tap, then scales the sum to 8 bits.
// Optional macro CONV_SEQ_SAT_EN: clamp the scaled result to 0..255 instead of truncating it.
module conv_sequencer #(
    parameter int TAPS   = 9,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pix_out,
    output logic [3:0]        win_addr,
    input  logic [7:0]        win_pix,
    input  logic [7:0]        win_coef,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_NOP = 3'b111;
    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MUL   = 3'd2,
        ACC   = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] prod;
    logic [3:0]        tap;
    logic [3:0]        addr_q;
    logic [7:0]        scaled;

`ifdef CONV_SEQ_SAT_EN
    logic signed [DATA_W-1:0] shifted;
    assign shifted = $signed(acc) >>> SHIFT;

    always_comb begin
        if (shifted[DATA_W-1])
            scaled = 8'd0;
        else if (|shifted[DATA_W-2:8])
            scaled = 8'hFF;
        else
            scaled = shifted[7:0];
    end
`else
    // Wrap-around: only the low byte of the shifted sum survives.
    assign scaled = 8'($signed(acc) >>> SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            prod    <= '0;
            tap     <= '0;
            addr_q  <= '0;
            pix_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        tap <= '0;
                    end
                end
                FETCH: addr_q <= tap;
                MUL:   prod <= alu_result;
                ACC: begin
                    acc <= alu_result;
                    if (tap != LAST_TAP)
                        tap <= tap + 4'd1;
                end
                OUT:   pix_out <= scaled;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        win_addr   = addr_q;
        alu_ctrl   = ALU_NOP;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: begin
                win_addr   = tap;
                state_next = MUL;
            end
            MUL: begin
                alu_ctrl   = ALU_MUL;
                alu_a      = {{(DATA_W-8){1'b0}}, win_pix};
                alu_b      = {{(DATA_W-8){win_coef[7]}}, win_coef};
                state_next = ACC;
            end
            ACC: begin
                alu_ctrl   = ALU_ADD;
                alu_a      = acc;
                alu_b      = prod;
                state_next = (tap == LAST_TAP) ? OUT : FETCH;
            end
            OUT:  state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
